// File: rtl/bp_pkg.sv
// Shared definitions for the BTB front-end control: opcodes, predictor
// encodings, the per-stage prediction record and the control FSM states.
package bp_pkg;

   // RISC-V control-transfer opcodes (instr[6:0])
   localparam logic [6:0] B_TYPE = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;

   // 2-bit saturating predictor encodings held in the BTB
   localparam logic [1:0] BP_STRONG_NT = 2'b00;
   localparam logic [1:0] BP_WEAK_NT   = 2'b01;
   localparam logic [1:0] BP_WEAK_T    = 2'b10;
   localparam logic [1:0] BP_STRONG_T  = 2'b11;

   typedef struct packed {
      logic        valid;
      logic        pred_taken;
      logic [31:0] pred_pc;
   } pred_info_t;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } ctrl_state_e;

   function automatic logic is_ctrl_op(input logic [6:0] op);
      return (op == B_TYPE) || (op == JAL) || (op == JALR);
   endfunction

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter32 (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_en,
   output logic [31:0] o_cnt
);

   // count enabled events, hold at the ceiling
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         o_cnt <= '0;
      else if (i_en && (o_cnt != 32'hFFFF_FFFF))
         o_cnt <= o_cnt + 32'd1;
   end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// BTB front-end control: carries predictions IF->ID->EX, resolves them in
// EX, raises flush/redirect on a mispredict, strobes BTB updates, clears
// the BTB after reset and keeps branch/mispredict statistics.
module branch_redirect_ctrl
   import bp_pkg::*;
#(
   parameter int BTB_DEPTH = 64,
   parameter int IDX_W     = $clog2(BTB_DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_stall,
   input  logic [31:0]      pc_IF,
   input  logic             i_pred_taken_IF,
   input  logic [31:0]      i_pred_pc_IF,
   input  logic [31:0]      instr_EX,
   input  logic [31:0]      pc_EX,
   input  logic             i_taken,
   input  logic [31:0]      i_alu_data,
   output logic             o_btb_we,
   output logic             o_btb_clr,
   output logic [IDX_W-1:0] o_btb_idx,
   output logic             o_flush,
   output logic             o_pc_sel_redirect,
   output logic [31:0]      o_pc_redirect,
   output logic             o_busy,
   output logic [31:0]      o_branch_cnt,
   output logic [31:0]      o_mispredict_cnt
);

   ctrl_state_e      state;
   logic [IDX_W-1:0] init_cnt;
   pred_info_t       if_id;
   pred_info_t       id_ex;
   logic             run;
   logic             is_ctrl;
   logic             eval;
   logic             mispred;

   // pc_IF is only meaningful to the PC mux; upper opcode bits are don't-care here
   logic unused_bits;
   assign unused_bits = ^{pc_IF, instr_EX[31:7]};

   assign run     = (state == RUN);
   assign is_ctrl = is_ctrl_op(instr_EX[6:0]);
   assign eval    = id_ex.valid && run;

   // resolve the EX prediction against the actual outcome
   always_comb begin
      mispred = 1'b0;
      if (eval) begin
         if (is_ctrl)
            mispred = (id_ex.pred_taken != i_taken) ||
                      (id_ex.pred_taken && i_taken && (id_ex.pred_pc != i_alu_data));
         else
            mispred = id_ex.pred_taken;  // BTB alias hit on a non-branch
      end
   end

   assign o_flush           = mispred;
   assign o_pc_sel_redirect = mispred;
   assign o_pc_redirect     = !mispred            ? 32'd0      :
                              (i_taken && is_ctrl) ? i_alu_data : pc_EX + 32'd4;
   assign o_btb_we          = eval && is_ctrl;
   assign o_btb_clr         = !run;
   assign o_busy            = !run;
   assign o_btb_idx         = run ? pc_EX[IDX_W+1:2] : init_cnt;

   // walk every BTB entry once after reset, then run until the next reset
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= INIT;
         init_cnt <= '0;
      end else if (state == INIT) begin
         if (init_cnt == IDX_W'(BTB_DEPTH - 1))
            state <= RUN;
         init_cnt <= init_cnt + 1'b1;
      end
   end

   // prediction pipeline; a flush overrides the stall hold/bubble
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         if_id <= '0;
         id_ex <= '0;
      end else if (mispred) begin
         if_id.valid <= 1'b0;
         id_ex.valid <= 1'b0;
      end else begin
         if (!i_stall)
            if_id <= '{valid: run, pred_taken: i_pred_taken_IF, pred_pc: i_pred_pc_IF};
         if (i_stall)
            id_ex.valid <= 1'b0;
         else
            id_ex <= if_id;
      end
   end

   sat_counter32 u_branch_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (o_btb_we),
      .o_cnt   (o_branch_cnt)
   );

   sat_counter32 u_mispredict_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (mispred),
      .o_cnt   (o_mispredict_cnt)
   );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed cases plus randomized traffic.
// The stimulus side queues the events (BTB write / flush) a reference model
// expects each cycle; the monitor pops and compares whenever the DUT shows one.
module tb_branch_redirect_ctrl;

   localparam logic [6:0] OP_B    = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_ADD  = 7'b0110011;
   localparam logic [31:0] BEQ_I  = {25'h0, OP_B};
   localparam logic [31:0] JALR_I = {25'h0, OP_JALR};
   localparam logic [31:0] ADD_I  = {25'h0, OP_ADD};

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_stall;
   logic [31:0] pc_IF;
   logic        i_pred_taken_IF;
   logic [31:0] i_pred_pc_IF;
   logic [31:0] instr_EX;
   logic [31:0] pc_EX;
   logic        i_taken;
   logic [31:0] i_alu_data;
   logic        o_btb_we;
   logic        o_btb_clr;
   logic [5:0]  o_btb_idx;
   logic        o_flush;
   logic        o_pc_sel_redirect;
   logic [31:0] o_pc_redirect;
   logic        o_busy;
   logic [31:0] o_branch_cnt;
   logic [31:0] o_mispredict_cnt;

   branch_redirect_ctrl #(.BTB_DEPTH(64)) dut (
      .i_clk             (i_clk),
      .i_rst_n           (i_rst_n),
      .i_stall           (i_stall),
      .pc_IF             (pc_IF),
      .i_pred_taken_IF   (i_pred_taken_IF),
      .i_pred_pc_IF      (i_pred_pc_IF),
      .instr_EX          (instr_EX),
      .pc_EX             (pc_EX),
      .i_taken           (i_taken),
      .i_alu_data        (i_alu_data),
      .o_btb_we          (o_btb_we),
      .o_btb_clr         (o_btb_clr),
      .o_btb_idx         (o_btb_idx),
      .o_flush           (o_flush),
      .o_pc_sel_redirect (o_pc_sel_redirect),
      .o_pc_redirect     (o_pc_redirect),
      .o_busy            (o_busy),
      .o_branch_cnt      (o_branch_cnt),
      .o_mispredict_cnt  (o_mispredict_cnt)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      bit          we;
      bit          fl;
      logic [31:0] rd;
      logic [5:0]  idx;
      logic [31:0] bc;
      logic [31:0] mc;
   } ev_t;
   ev_t q[$];
   ev_t e;

   // Reference model: what the prediction sitting in ID and in EX is, plus counts
   bit          m_id_v, m_id_t, m_ex_v, m_ex_t;
   logic [31:0] m_id_pc, m_ex_pc, m_bc, m_mc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic model_reset();
      m_id_v = 0; m_id_t = 0; m_id_pc = 0;
      m_ex_v = 0; m_ex_t = 0; m_ex_pc = 0;
      m_bc = 0; m_mc = 0;
   endtask

   // Drive one cycle of inputs, queue the expected event, advance the model
   task automatic drive(input bit st, input bit pt, input logic [31:0] ppc,
                        input logic [31:0] ins, input logic [31:0] pc,
                        input bit tk, input logic [31:0] alu);
      bit ctl, mis, we;
      logic [6:0] op;
      i_stall = st; i_pred_taken_IF = pt; i_pred_pc_IF = ppc;
      instr_EX = ins; pc_EX = pc; i_taken = tk; i_alu_data = alu;
      pc_IF = pc + 32'd8;
      op  = ins[6:0];
      ctl = (op == OP_B) || (op == OP_JAL) || (op == OP_JALR);
      mis = 0;
      if (m_ex_v) begin
         if (ctl) mis = (m_ex_t != tk) || (m_ex_t && tk && (m_ex_pc != alu));
         else     mis = m_ex_t;
      end
      we = m_ex_v && ctl;
      if (we || mis)
         q.push_back('{cyc, we, mis, (tk && ctl) ? alu : pc + 32'd4, pc[7:2], m_bc, m_mc});
      if (we  && m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
      if (mis && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
      if (mis) begin
         m_id_v = 0; m_ex_v = 0;
      end else if (st) begin
         m_ex_v = 0;
      end else begin
         m_ex_v = m_id_v; m_ex_t = m_id_t; m_ex_pc = m_id_pc;
         m_id_v = 1;      m_id_t = pt;     m_id_pc = ppc;
      end
   endtask

   // Put a prediction into IF, two cycles later present the instruction in EX
   task automatic dir3(input bit pt, input logic [31:0] ppc, input logic [31:0] ins,
                       input logic [31:0] pc, input bit tk, input logic [31:0] alu,
                       input bit st);
      drive(0, pt, ppc, ADD_I, 32'h0, 0, 32'h0); step();
      drive(0, 0, 32'h0, ADD_I, 32'h4, 0, 32'h0); step();
      drive(st, 0, 32'h0, ins, pc, tk, alu);
   endtask

   task automatic init_walk(input int n);
      for (int k = 0; k < n; k++) begin
         chk("init_idx",  {26'h0, o_btb_idx}, 32'(k));
         chk("init_clr",  o_btb_clr, 1);
         chk("init_busy", o_busy, 1);
         chk("init_we",   o_btb_we, 0);
         step();
      end
   endtask

   // Monitor: compare every BTB-write/flush the DUT presents with the queue
   always @(negedge i_clk) begin
      if (i_rst_n === 1'b1 && (o_btb_we === 1'b1 || o_flush === 1'b1)) begin
         if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_event actual we=%b flush=%b required none (cyc %0d)",
                     o_btb_we, o_flush, cyc);
         end else begin
            e = q.pop_front();
            chk("ev_cycle", cyc, e.cyc);
            chk("ev_we", o_btb_we, e.we);
            chk("ev_flush", o_flush, e.fl);
            chk("ev_sel", o_pc_sel_redirect, e.fl);
            chk("ev_idx", {26'h0, o_btb_idx}, {26'h0, e.idx});
            if (e.fl) chk("ev_redirect", o_pc_redirect, e.rd);
            chk("ev_branch_cnt", o_branch_cnt, e.bc);
            chk("ev_mispred_cnt", o_mispredict_cnt, e.mc);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int wecnt;
      logic [31:0] r, ins, pc, ppc, alu;
      logic [6:0]  op;
      bit st, pt, tk;
      model_reset();
      i_rst_n = 0; i_stall = 0; pc_IF = 0; i_pred_taken_IF = 1; i_pred_pc_IF = 32'h40;
      instr_EX = BEQ_I; pc_EX = 0; i_taken = 1; i_alu_data = 32'h40;
      step(); step();
      chk("rst_busy", o_busy, 1);
      chk("rst_clr", o_btb_clr, 1);
      chk("rst_idx", {26'h0, o_btb_idx}, 0);
      chk("rst_we", o_btb_we, 0);
      chk("rst_flush", o_flush, 0);
      chk("rst_sel", o_pc_sel_redirect, 0);
      chk("rst_redirect", o_pc_redirect, 0);
      chk("rst_bcnt", o_branch_cnt, 0);
      chk("rst_mcnt", o_mispredict_cnt, 0);

      // reset in the middle of INIT restarts the walk at 0
      i_rst_n = 1;
      init_walk(20);
      chk("mid_idx20", {26'h0, o_btb_idx}, 20);
      i_rst_n = 0;
      #1;
      chk("mid_rst_idx", {26'h0, o_btb_idx}, 0);
      chk("mid_rst_busy", o_busy, 1);
      step();
      i_rst_n = 1;
      init_walk(64);
      chk("run_busy", o_busy, 0);
      chk("run_clr", o_btb_clr, 0);
      model_reset();

      // BEQ predicted not-taken, actually taken
      dir3(0, 32'h0, BEQ_I, 32'h100, 1, 32'h140, 0); #1;
      chk("beq1_flush", o_flush, 1);
      chk("beq1_redirect", o_pc_redirect, 32'h140);
      chk("beq1_we", o_btb_we, 1);
      chk("beq1_idx", {26'h0, o_btb_idx}, 0);
      step();
      chk("beq1_bcnt", o_branch_cnt, 1);
      chk("beq1_mcnt", o_mispredict_cnt, 1);

      // BEQ predicted taken, actually not-taken
      dir3(1, 32'h140, BEQ_I, 32'h104, 0, 32'h999, 0); #1;
      chk("beq2_flush", o_flush, 1);
      chk("beq2_redirect", o_pc_redirect, 32'h108);
      step();
      chk("beq2_mcnt", o_mispredict_cnt, 2);

      // JALR target mismatch, then target match
      dir3(1, 32'h200, JALR_I, 32'h1F0, 1, 32'h300, 0); #1;
      chk("jalr_bad_redirect", o_pc_redirect, 32'h300);
      chk("jalr_bad_flush", o_flush, 1);
      step();
      dir3(1, 32'h200, JALR_I, 32'h1F0, 1, 32'h200, 0); #1;
      chk("jalr_ok_flush", o_flush, 0);
      chk("jalr_ok_we", o_btb_we, 1);
      step();

      // stale alias on an ADD
      dir3(1, 32'h1C0, ADD_I, 32'h180, 0, 32'h0, 0); #1;
      chk("alias_flush", o_flush, 1);
      chk("alias_redirect", o_pc_redirect, 32'h184);
      chk("alias_we", o_btb_we, 0);
      step();

      // stall held three cycles across a resolving branch
      dir3(0, 32'h0, BEQ_I, 32'h110, 0, 32'h0, 1); #1;
      wecnt = int'(o_btb_we);
      step();
      for (int k = 0; k < 2; k++) begin
         drive(1, 0, 32'h0, BEQ_I, 32'h110, 0, 32'h0); #1;
         wecnt += int'(o_btb_we);
         step();
      end
      chk("stall_one_we", wecnt, 1);

      // flush coincident with stall must drop the ID prediction
      drive(0, 0, 32'h0, ADD_I, 32'h0, 0, 32'h0); step();
      drive(0, 1, 32'h500, ADD_I, 32'h4, 0, 32'h0); step();
      drive(1, 0, 32'h0, BEQ_I, 32'h120, 1, 32'h160); #1;
      chk("fs_flush", o_flush, 1);
      step();
      drive(0, 0, 32'h0, ADD_I, 32'h124, 0, 32'h0); #1;
      chk("fs_next1", o_flush, 0);
      step();
      drive(0, 0, 32'h0, ADD_I, 32'h128, 0, 32'h0); #1;
      chk("fs_next2", o_flush, 0);
      step();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         r   = $urandom();
         st  = ($urandom_range(0, 3) == 0);
         pt  = 1'($urandom_range(0, 1));
         ppc = 32'($urandom_range(0, 7)) << 4;
         case ($urandom_range(0, 3))
            0:       op = OP_B;
            1:       op = OP_JAL;
            2:       op = OP_JALR;
            default: op = OP_ADD;
         endcase
         ins = {r[31:7], op};
         pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 1023)) << 2;
         tk  = (op == OP_JAL || op == OP_JALR) ? 1'b1 : 1'($urandom_range(0, 1));
         alu = ($urandom_range(0, 1) == 1 && m_ex_v) ? m_ex_pc : 32'($urandom_range(0, 7)) << 4;
         drive(st, pt, ppc, ins, pc, tk, alu);
         step();
      end
      for (int n = 0; n < 3; n++) begin
         drive(0, 0, 32'h0, ADD_I, 32'h0, 0, 32'h0);
         step();
      end
      chk("queue_drained", q.size(), 0);
      chk("final_bcnt", o_branch_cnt, m_bc);
      chk("final_mcnt", o_mispredict_cnt, m_mc);

      // reset in RUN clears the counters and re-enters INIT
      i_rst_n = 0;
      #1;
      chk("rerst_bcnt", o_branch_cnt, 0);
      chk("rerst_mcnt", o_mispredict_cnt, 0);
      chk("rerst_busy", o_busy, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Front-end control for the BTB branch predictor. Carries each fetched instruction's prediction from IF to EX and compares it against the resolved outcome. On a mispredict it raises flush and redirect toward the PC mux, and it drives the BTB write-enable in place of a gated clock. After reset it walks every BTB entry through a clear sequence, and it keeps branch and mispredict statistics.

## Interface
- BTB_DEPTH, 64, BTB entry count, power of two
- IDX_W, $clog2(BTB_DEPTH), BTB index width
- i_clk  in  1  core clock
- i_rst_n  in  1  asynchronous active-low reset
- i_stall  in  1  hazard stall; IF/ID hold, bubble enters EX
- pc_IF  in  32  fetch PC
- i_pred_taken_IF  in  1  BTB hit-and-taken for pc_IF
- i_pred_pc_IF  in  32  BTB predicted target for pc_IF
- instr_EX  in  32  instruction in EX
- pc_EX  in  32  PC of instruction in EX
- i_taken  in  1  resolved taken (branch compare, or 1 for JAL/JALR)
- i_alu_data  in  32  resolved target
- o_btb_we  out  1  BTB entry write/update strobe
- o_btb_clr  out  1  BTB entry clear strobe (init only)
- o_btb_idx  out  IDX_W  BTB index for we/clr
- o_flush  out  1  kill IF and ID contents
- o_pc_sel_redirect  out  1  PC mux selects o_pc_redirect
- o_pc_redirect  out  32  corrected next PC
- o_busy  out  1  init in progress; front-end must hold
- o_branch_cnt  out  32  resolved control instructions
- o_mispredict_cnt  out  32  mispredicts

## Operation
- FSM states:
  - INIT: reset state. Asserts o_busy and o_btb_clr, with o_btb_idx = init counter. The counter runs 0..BTB_DEPTH-1, one entry per cycle. The FSM goes to RUN after index BTB_DEPTH-1.
  - RUN: normal operation; stays in RUN until reset.
- Reset values: state INIT, init counter 0, all pipeline valid bits 0, both counters 0. With reset asserted, all outputs are 0 except o_busy=1 and o_btb_clr=1.
- Prediction pipeline: two register stages, IF->ID and ID->EX. Each holds {valid, pred_taken, pred_pc}.
  - IF->ID captures i_pred_taken_IF/i_pred_pc_IF with valid=1 when !i_stall && !o_flush && RUN.
  - ID->EX takes the ID contents; it takes a bubble (valid=0) on i_stall.
  - o_flush clears valid in both stages. Flush wins over stall.
- Control instruction: instr_EX[6:0] is 7'b1100011, 7'b1101111 or 7'b1100111.
- EX evaluation, only when ex_valid and RUN. Mispredict is any of:
  - control instruction with pred_taken != i_taken
  - control instruction with pred_taken && i_taken && pred_pc != i_alu_data
  - non-control instruction with pred_taken=1 (stale alias)
- On mispredict: o_flush=1, o_pc_sel_redirect=1. o_pc_redirect = i_taken && control instruction ? i_alu_data : pc_EX+32'd4 (mod 2^32).
- o_btb_we=1 for every evaluated control instruction, with o_btb_idx = pc_EX[IDX_W+1:2].
- In RUN, o_btb_idx = pc_EX[IDX_W+1:2] whenever o_btb_we=0.
- Counters (saturating at 32'hFFFF_FFFF):
  - o_branch_cnt increments on each o_btb_we.
  - o_mispredict_cnt increments on each mispredict.
- In INIT: o_btb_we, o_flush and o_pc_sel_redirect are 0, and EX evaluation is suppressed.

## Timing
- o_btb_we, o_flush, o_pc_sel_redirect and o_pc_redirect are combinational from EX-stage registers and inputs in the resolve cycle. The BTB, PC register and pipeline-valid clears act on the next i_clk rising edge.
- Mispredict penalty: 2 cycles (IF and ID killed). Redirected fetch is at pc_IF on the cycle after the flush.
- INIT lasts exactly BTB_DEPTH cycles after reset deassertion. o_busy falls in the first RUN cycle.
- i_rst_n assertion at any time, including mid-INIT, returns immediately to INIT with index 0. Counters clear.
- i_stall in the resolve cycle does not suppress evaluation. The EX instruction is evaluated once, because the following cycle holds a bubble.
- Flush coincident with i_stall: flush takes effect and the stall has no effect on the pipeline registers.

## Structure
- Package bp_pkg holds:
  - opcode constants (B_type, JAL, JALR)
  - the 2-bit predictor state encodings
  - typedef pred_info_t {valid, pred_taken, pred_pc[31:0]}
  - typedef ctrl_state_e {INIT, RUN}
- One sub-module, sat_counter32 (increment-enable, saturating), instantiated twice.

## Test plan
- Reset release with BTB_DEPTH=64 -> o_btb_clr high with o_btb_idx 0..63 over 64 cycles. o_busy falls on cycle 64; no o_btb_we during INIT.
- BEQ at pc 0x100, predicted not-taken, i_taken=1, i_alu_data=0x140 -> o_flush=1, o_pc_redirect=0x140, o_btb_we=1, o_btb_idx=0x00. Counters 1/1.
- BEQ at 0x104, predicted taken to 0x140, i_taken=0 -> redirect 0x108, flush, mispredict_cnt+1.
- JALR predicted taken to 0x200, resolves to 0x300 -> redirect 0x300. Same target 0x200 -> no flush, o_btb_we=1.
- ADD at 0x180 arriving with pred_taken=1 -> flush, redirect 0x184, o_btb_we=0.
- i_stall held 3 cycles around a resolving branch -> exactly one o_btb_we. Flush coincident with stall clears ID/EX valid. Reset mid-INIT at index 20 restarts at index 0.
